// File: rtl/lstm_cell_seq.sv
// lstm_cell_seq: sequential fixed-point LSTM cell, one timestep per run.
// Reads W/U/bias coefficients from an external ROM with a 1-cycle read
// latency. Each gate row is accumulated one coefficient per cycle, then
// the cell and hidden states are updated one unit per cycle.
// Optional feature macro: LSTM_SAT_EN. When defined, every reduction to
// DATA_WIDTH saturates and sets sat_flag. When undefined, reductions wrap
// and sat_flag stays 0.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   start        - run request (accepted only when idle)
//   clear_state  - sampled with start; run from zero h/c instead of h/c regs
//   x            - INPUT_SIZE packed words, latched on start (x[0] in LSBs)
//   coef_addr    - ROM address; coef_data is returned one cycle later
//   busy, done   - run in progress / one-cycle completion pulse
//   h, c         - HIDDEN_SIZE packed hidden / cell state words
//   sat_flag     - sticky per run: a saturation occurred
module lstm_cell_seq #(
   parameter int INPUT_SIZE  = 2,
   parameter int HIDDEN_SIZE = 2,
   parameter int DATA_WIDTH  = 16,
   parameter int FRAC_BITS   = 8
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic                                  clear_state,
   input  logic [INPUT_SIZE*DATA_WIDTH-1:0]      x,
   output logic [$clog2(4*HIDDEN_SIZE*(INPUT_SIZE+HIDDEN_SIZE+1))-1:0] coef_addr,
   input  logic [DATA_WIDTH-1:0]                 coef_data,
   output logic                                  busy,
   output logic                                  done,
   output logic [HIDDEN_SIZE*DATA_WIDTH-1:0]     h,
   output logic [HIDDEN_SIZE*DATA_WIDTH-1:0]     c,
   output logic                                  sat_flag
);
   localparam int DW    = DATA_WIDTH;
   localparam int L     = INPUT_SIZE + HIDDEN_SIZE + 1;
   localparam int ROWS  = 4 * HIDDEN_SIZE;
   localparam int NADDR = ROWS * L;
   localparam int AW    = $clog2(NADDR);
   localparam int PW    = 2 * DW;
   localparam int ACCW  = 2 * DW + $clog2(L);
   localparam int KW    = $clog2(L);
   localparam int RW    = $clog2(ROWS);
   localparam int UW    = (HIDDEN_SIZE > 1) ? $clog2(HIDDEN_SIZE) : 1;
   localparam int ONE_I = 1 << FRAC_BITS;

   localparam logic signed [DW-1:0]   ONE_D  = ONE_I[DW-1:0];
   localparam logic signed [DW-1:0]   NONE_D = -ONE_D;
   localparam logic signed [DW:0]     ONE_X  = ONE_I[DW:0];
   localparam logic signed [DW:0]     HALF_X = (ONE_I >> 1);
   localparam logic signed [ACCW-1:0] MAXV   = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACCW-1:0] MINV   = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, MAC, DRAIN, C_UPD, H_UPD, DONE} state_t;

   // full-precision signed product
   function automatic logic signed [PW-1:0] mul(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
      return $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});
   endfunction

   function automatic logic signed [ACCW-1:0] sx(input logic signed [PW-1:0] v);
      return {{(ACCW-PW){v[PW-1]}}, v};
   endfunction

   function automatic logic signed [DW-1:0] red(input logic signed [ACCW-1:0] v);
`ifdef LSTM_SAT_EN
      if (v > MAXV) return MAXV[DW-1:0];
      if (v < MINV) return MINV[DW-1:0];
`endif
      return v[DW-1:0];
   endfunction

   function automatic logic sat_hit(input logic signed [ACCW-1:0] v);
`ifdef LSTM_SAT_EN
      return (v > MAXV) || (v < MINV);
`else
      return 1'b0 & v[0];
`endif
   endfunction

   // hard sigmoid: p/4 + 0.5, clamped to [0, 1]
   function automatic logic signed [DW-1:0] sigm(input logic signed [DW-1:0] p);
      logic signed [DW:0] t;
      t = ($signed({p[DW-1], p}) >>> 2) + HALF_X;
      if (t[DW])     return '0;
      if (t > ONE_X) return ONE_X[DW-1:0];
      return t[DW-1:0];
   endfunction

   // hard tanh: clamp to [-1, 1]
   function automatic logic signed [DW-1:0] tanh_f(input logic signed [DW-1:0] p);
      if (p > ONE_D)  return ONE_D;
      if (p < NONE_D) return NONE_D;
      return p;
   endfunction

   state_t                 state_q;
   logic [AW-1:0]          addr_q;
   logic [KW-1:0]          k_q, kd_q;     // issue-side / absorb-side column
   logic [RW-1:0]          r_q, rd_q;     // issue-side / absorb-side row
   logic                   vd_q;          // coef_data holds a datum to absorb
   logic [UW-1:0]          u_q;
   logic signed [ACCW-1:0] acc_q;
   logic signed [DW-1:0]   gate_q [ROWS];
   logic signed [DW-1:0]   x_q [INPUT_SIZE];
   logic signed [DW-1:0]   h_q [HIDDEN_SIZE];
   logic signed [DW-1:0]   c_q [HIDDEN_SIZE];
   logic                   clr_q, busy_q, done_q, sat_q, satp_q;

   logic signed [DW-1:0]   cd;
   logic signed [DW-1:0]   opv [1 << KW];
   logic                   is_bias, is_g;
   logic signed [ACCW-1:0] term_d, acc_d, csum_d, hval_d;
   logic signed [DW-1:0]   red_acc, act_d;
   logic signed [DW-1:0]   gi, gf, gg, go, cp, cn;

   assign cd = coef_data;

   always_comb begin
      for (int j = 0; j < (1 << KW); j++) opv[j] = '0;
      for (int j = 0; j < INPUT_SIZE; j++) opv[j] = x_q[j];
      for (int j = 0; j < HIDDEN_SIZE; j++) opv[INPUT_SIZE+j] = clr_q ? '0 : h_q[j];
      // last column of a row is the bias, added without scaling
      is_bias = (kd_q == KW'(L-1));
      term_d  = is_bias ? {{(ACCW-DW){cd[DW-1]}}, cd} : sx(mul(cd, opv[kd_q]) >>> FRAC_BITS);
      acc_d   = ((kd_q == '0) ? '0 : acc_q) + term_d;
      red_acc = red(acc_d);
      is_g    = (rd_q >= RW'(2*HIDDEN_SIZE)) && (rd_q < RW'(3*HIDDEN_SIZE));
      act_d   = is_g ? tanh_f(red_acc) : sigm(red_acc);

      gi = '0; gf = '0; gg = '0; go = '0; cp = '0; cn = '0;
      for (int j = 0; j < HIDDEN_SIZE; j++) begin
         if (u_q == UW'(j)) begin
            gi = gate_q[j];
            gf = gate_q[HIDDEN_SIZE+j];
            gg = gate_q[2*HIDDEN_SIZE+j];
            go = gate_q[3*HIDDEN_SIZE+j];
            cp = clr_q ? '0 : c_q[j];
            cn = c_q[j];
         end
      end
      csum_d = sx(mul(gf, cp) >>> FRAC_BITS) + sx(mul(gi, gg) >>> FRAC_BITS);
      hval_d = sx(mul(go, tanh_f(cn)) >>> FRAC_BITS);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         k_q     <= '0;
         kd_q    <= '0;
         r_q     <= '0;
         rd_q    <= '0;
         vd_q    <= 1'b0;
         u_q     <= '0;
         acc_q   <= '0;
         clr_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sat_q   <= 1'b0;
         satp_q  <= 1'b0;
         for (int j = 0; j < ROWS; j++) gate_q[j] <= '0;
         for (int j = 0; j < INPUT_SIZE; j++) x_q[j] <= '0;
         for (int j = 0; j < HIDDEN_SIZE; j++) begin
            h_q[j] <= '0;
            c_q[j] <= '0;
         end
      end else begin
         // absorb the datum addressed one cycle earlier (MAC and DRAIN)
         if ((state_q == MAC || state_q == DRAIN) && vd_q) begin
            acc_q <= acc_d;
            if (is_bias) begin
               gate_q[rd_q] <= act_d;
               satp_q       <= satp_q | sat_hit(acc_d);
            end
         end
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= MAC;
                  busy_q  <= 1'b1;
                  sat_q   <= 1'b0;
                  satp_q  <= 1'b0;
                  clr_q   <= clear_state;
                  addr_q  <= '0;
                  k_q     <= '0;
                  r_q     <= '0;
                  vd_q    <= 1'b0;
                  for (int j = 0; j < INPUT_SIZE; j++) x_q[j] <= x[j*DW +: DW];
               end
            end
            MAC: begin
               vd_q <= 1'b1;
               kd_q <= k_q;
               rd_q <= r_q;
               if (addr_q == AW'(NADDR-1)) begin
                  state_q <= DRAIN;
               end else begin
                  addr_q <= addr_q + 1'b1;
                  if (k_q == KW'(L-1)) begin
                     k_q <= '0;
                     r_q <= r_q + 1'b1;
                  end else begin
                     k_q <= k_q + 1'b1;
                  end
               end
            end
            DRAIN: begin
               vd_q    <= 1'b0;
               u_q     <= '0;
               state_q <= C_UPD;
            end
            C_UPD: begin
               for (int j = 0; j < HIDDEN_SIZE; j++)
                  if (u_q == UW'(j)) c_q[j] <= red(csum_d);
               // row-end saturations are folded in here so sat_flag only moves during updates
               sat_q <= sat_q | satp_q | sat_hit(csum_d);
               if (u_q == UW'(HIDDEN_SIZE-1)) begin
                  u_q     <= '0;
                  state_q <= H_UPD;
               end else begin
                  u_q <= u_q + 1'b1;
               end
            end
            H_UPD: begin
               for (int j = 0; j < HIDDEN_SIZE; j++)
                  if (u_q == UW'(j)) h_q[j] <= red(hval_d);
               sat_q <= sat_q | sat_hit(hval_d);
               if (u_q == UW'(HIDDEN_SIZE-1)) begin
                  u_q     <= '0;
                  state_q <= DONE;
               end else begin
                  u_q <= u_q + 1'b1;
               end
            end
            DONE: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign coef_addr = addr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sat_flag  = sat_q;

   always_comb begin
      for (int j = 0; j < HIDDEN_SIZE; j++) begin
         h[j*DW +: DW] = h_q[j];
         c[j*DW +: DW] = c_q[j];
      end
   end
endmodule

// File: tb/tb_lstm_cell_seq.sv
// Directed bench for lstm_cell_seq (I=2, H=2, DW=16, F=8). ROM is modelled
// as a registered lookup table; expected values are hand-computed.
module tb_lstm_cell_seq;
   localparam int I = 2, H = 2, DW = 16, F = 8;

   logic          clk = 1'b0;
   logic          rst_n, start, clear_state;
   logic [I*DW-1:0] x;
   logic [5:0]    coef_addr;
   logic [DW-1:0] coef_data;
   logic          busy, done, sat_flag;
   logic [H*DW-1:0] h, c;

   logic [DW-1:0] rom [0:63];
   int nchk = 0, nfail = 0;
   int lat, ndone;

   always #5 clk = ~clk;
   always @(posedge clk) coef_data <= rom[coef_addr];

   lstm_cell_seq #(.INPUT_SIZE(I), .HIDDEN_SIZE(H), .DATA_WIDTH(DW), .FRAC_BITS(F)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear_state(clear_state), .x(x),
      .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy), .done(done),
      .h(h), .c(c), .sat_flag(sat_flag));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input int exp);
      chk(tag, {16'h0, obs}, {16'h0, 16'(exp)});
   endtask

   task automatic chk_hc(input string tag, input int h0, input int h1, input int c0, input int c1);
      chk16({tag, "_h0"}, h[15:0], h0);
      chk16({tag, "_h1"}, h[31:16], h1);
      chk16({tag, "_c0"}, c[15:0], c0);
      chk16({tag, "_c1"}, c[31:16], c1);
   endtask

   task automatic rom_clear();
      for (int i = 0; i < 64; i++) rom[i] = '0;
   endtask

   // i,f,o biases 1.0*4 (sigmoid saturates at 1.0), g bias 0.5
   task automatic rom_bias();
      rom_clear();
      rom[4] = 16'd1024; rom[9] = 16'd1024; rom[14] = 16'd1024; rom[19] = 16'd1024;
      rom[34] = 16'd1024; rom[39] = 16'd1024;
      rom[24] = 16'd128;  rom[29] = 16'd128;
   endtask

   // start at edge 0, then run 60 edges; lat = first edge with done high
   task automatic run(input logic clr, input int restart_at, input int rst_at,
                      output int lat_o, output int ndone_o);
      lat_o = -1; ndone_o = 0;
      @(negedge clk); start = 1'b1; clear_state = clr;
      @(posedge clk); #1;
      chk("busy_after_start", {31'h0, busy}, 32'd1);
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         start = (n == restart_at);
         rst_n = !(n == rst_at);
         @(posedge clk); #1;
         if (done === 1'b1) begin
            ndone_o++;
            if (lat_o < 0) lat_o = n;
         end
         if (n == 20 && rst_at == 0) chk("busy_mid_run", {31'h0, busy}, 32'd1);
         if (n == rst_at) begin
            chk("rst_busy", {31'h0, busy}, 32'd0);
            chk("rst_done", {31'h0, done}, 32'd0);
            chk("rst_sat", {31'h0, sat_flag}, 32'd0);
            chk_hc("rst", 0, 0, 0, 0);
         end
      end
      @(negedge clk); start = 1'b0; rst_n = 1'b1;
   endtask

   task automatic chk_run(input string tag);
      chk({tag, "_latency"}, lat, 32'd46);
      chk({tag, "_done_pulses"}, ndone, 32'd1);
      chk({tag, "_busy_end"}, {31'h0, busy}, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; clear_state = 1'b0; x = '0;
      rom_clear();

      // reset
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", {31'h0, busy}, 32'd0);
      chk("reset_done", {31'h0, done}, 32'd0);
      chk("reset_sat", {31'h0, sat_flag}, 32'd0);
      chk("reset_addr", {26'h0, coef_addr}, 32'd0);
      chk_hc("reset", 0, 0, 0, 0);
      @(negedge clk); rst_n = 1'b1;

      // zero ROM; a second start at cycle 5 must be ignored
      x = {16'(-50), 16'(100)};
      run(1'b0, 5, 0, lat, ndone);
      chk_run("zero");
      chk_hc("zero", 0, 0, 0, 0);
      chk("zero_sat", {31'h0, sat_flag}, 32'd0);

      // bias-only: c += 0.5 per run with i=f=o=1.0
      rom_bias();
      run(1'b1, 0, 0, lat, ndone);
      chk_run("bias1");
      chk_hc("bias1", 128, 128, 128, 128);
      run(1'b0, 0, 0, lat, ndone);
      chk_run("bias2");
      chk_hc("bias2", 256, 256, 256, 256);
      run(1'b1, 0, 0, lat, ndone);
      chk_run("bias3");
      chk_hc("bias3", 128, 128, 128, 128);
      chk("bias3_sat", {31'h0, sat_flag}, 32'd0);

      // mixed W/U/bias with h_prev = c_prev = {128,128}
      rom_clear();
      rom[4] = 16'd1024; rom[9] = 16'd1024; rom[19] = 16'd1024; rom[34] = 16'd1024;
      rom[20] = 16'd128; rom[24] = 16'd3;
      rom[25] = 16'd3; rom[26] = 16'd256; rom[27] = 16'(-128); rom[28] = 16'(-1);
      run(1'b0, 0, 0, lat, ndone);
      chk_run("mixed");
      chk_hc("mixed", 117, 7, 117, 14);

      // W[0][0] * x[0] overflows the i0 row
      rom_clear();
      rom[0] = 16'd32767; rom[24] = 16'd128;
      x = {16'd0, 16'd32767};
      run(1'b1, 0, 0, lat, ndone);
      chk_run("sat");
`ifdef LSTM_SAT_EN
      chk_hc("sat", 64, 0, 128, 0);
      chk("sat_flag", {31'h0, sat_flag}, 32'd1);
`else
      chk_hc("wrap", 16, 0, 32, 0);
      chk("wrap_flag", {31'h0, sat_flag}, 32'd0);
`endif

      // reset at cycle 10 of a run: state cleared, no done afterwards
      rom_bias();
      x = '0;
      run(1'b1, 0, 10, lat, ndone);
      chk("midrst_no_done", lat, 32'hFFFF_FFFF);
      chk_hc("midrst_after", 0, 0, 0, 0);

      // block recovers after the mid-run reset
      run(1'b0, 0, 0, lat, ndone);
      chk_run("recover");
      chk_hc("recover", 128, 128, 128, 128);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
